// File: rtl/dinorun_pkg.sv
// Shared types and defaults for the dinorun game logic.
// Holds the obstacle scheduler state encoding and its spawn-threshold rule.
package dinorun_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE     = 2'd0,
        SCHED_COOLDOWN = 2'd1,
        SCHED_ARMED    = 2'd2,
        SCHED_GRANT    = 2'd3
    } sched_state_t;

    localparam int unsigned GAP_START_DEFAULT = 60;
    localparam int unsigned GAP_STEP_DEFAULT  = 6;
    localparam int unsigned GAP_FLOOR_DEFAULT = 24;

    localparam logic [2:0] LEVEL_MAX = 3'd7;

    // Spawn odds rise two sixteenths per level, capped at certainty.
    function automatic logic [4:0] spawn_threshold(input logic [2:0] level);
        logic [4:0] thr;
        thr = 5'd4 + {1'b0, level, 1'b0};
        return (thr > 5'd16) ? 5'd16 : thr;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int off = 0; off < int'(N); off++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!valid_o && req_i[i] && (((int'(ptr_i) + off) % int'(N)) == i)) begin
                    gnt_o[i] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: frame-gap cooldown, level ramp and round-robin slot grant.
// Emits a one-cycle one-hot spawn pulse to the chosen obstacle slot.
module obstacle_scheduler
    import dinorun_pkg::*;
#(
    parameter int unsigned           NUM_SLOTS  = 3,
    parameter logic [NUM_SLOTS-1:0]  BIRD_MASK  = 3'b011,
    parameter int unsigned           BIRD_LEVEL = 1,
    parameter int unsigned           GAP_START  = GAP_START_DEFAULT,
    parameter int unsigned           GAP_STEP   = GAP_STEP_DEFAULT,
    parameter int unsigned           GAP_FLOOR  = GAP_FLOOR_DEFAULT,
    parameter int unsigned           GAP_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 frame_i,
    input  logic                 run_i,
    input  logic                 clear_i,
    input  logic [15:0]          rand_i,
    input  logic                 level_up_i,
    input  logic [NUM_SLOTS-1:0] busy_i,
    output logic [NUM_SLOTS-1:0] spawn_o,
    output logic [2:0]           level_o,
    output logic [GAP_W-1:0]     gap_o
);

    localparam int unsigned PTR_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CALC_W = GAP_W + 4;

    sched_state_t         state_q, state_d;
    logic [2:0]           level_q, level_d;
    logic [GAP_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [PTR_W-1:0]     slot_q, slot_d;
    logic [NUM_SLOTS-1:0] spawn_q, spawn_d;

    logic [CALC_W-1:0]    gap_prod, gap_calc;
    logic [4:0]           thr;
    logic                 attempt_ok;
    logic [GAP_W-1:0]     jitter;
    logic                 bird_ok;
    logic [NUM_SLOTS-1:0] eligible;
    logic [NUM_SLOTS-1:0] arb_gnt;
    logic                 arb_valid;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 unused_rand;

    // Subtract only when the result stays above the floor, so it never wraps.
    always_comb begin
        gap_prod = CALC_W'(level_q) * CALC_W'(GAP_STEP);
        if (gap_prod + CALC_W'(GAP_FLOOR) >= CALC_W'(GAP_START)) begin
            gap_calc = CALC_W'(GAP_FLOOR);
        end else begin
            gap_calc = CALC_W'(GAP_START) - gap_prod;
        end
    end

    assign gap_o       = GAP_W'(gap_calc);
    assign thr         = spawn_threshold(level_q);
    assign attempt_ok  = ({1'b0, rand_i[3:0]} < thr);
    assign jitter      = GAP_W'(rand_i[7:4]);
    assign bird_ok     = (32'(level_q) >= BIRD_LEVEL);
    assign eligible    = ~busy_i & (~BIRD_MASK | {NUM_SLOTS{bird_ok}});
    assign unused_rand = ^rand_i[15:8];

    rr_arbiter #(
        .N     (NUM_SLOTS),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i   (eligible),
        .ptr_i   (rr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (arb_gnt[i]) gnt_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        slot_d  = slot_q;
        spawn_d = spawn_q;
        if (clear_i) begin
            state_d = SCHED_IDLE;
            level_d = '0;
            cnt_d   = '0;
            rr_d    = '0;
            slot_d  = '0;
            spawn_d = '0;
        end else if (run_i) begin
            spawn_d = '0;
            if (level_up_i && level_q != LEVEL_MAX) level_d = level_q + 3'd1;
            case (state_q)
                SCHED_IDLE: begin
                    cnt_d   = gap_o;
                    state_d = SCHED_COOLDOWN;
                end
                SCHED_COOLDOWN: begin
                    if (frame_i) begin
                        if (cnt_q <= GAP_W'(1)) state_d = SCHED_ARMED;
                        else                    cnt_d   = cnt_q - GAP_W'(1);
                    end
                end
                SCHED_ARMED: begin
                    if (frame_i && attempt_ok && arb_valid) begin
                        slot_d  = gnt_idx;
                        spawn_d = arb_gnt;
                        state_d = SCHED_GRANT;
                    end
                end
                SCHED_GRANT: begin
                    rr_d    = (slot_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : slot_q + PTR_W'(1);
                    cnt_d   = gap_o + jitter;
                    state_d = SCHED_COOLDOWN;
                end
                default: state_d = SCHED_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCHED_IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            slot_q  <= '0;
            spawn_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            slot_q  <= slot_d;
            spawn_q <= spawn_d;
        end
    end

    // A frozen GRANT keeps its pulse pending until the game resumes.
    assign spawn_o = spawn_q & {NUM_SLOTS{run_i}};
    assign level_o = level_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: directed scenarios plus random traffic
// compared against a frame-counting reference model.
module tb_obstacle_scheduler;

    localparam int N = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        frame_i, run_i, clear_i, level_up_i;
    logic [15:0] rand_i;
    logic [2:0]  busy_i;
    logic [2:0]  spawn_o;
    logic [2:0]  level_o;
    logic [7:0]  gap_o;

    always #20 clk_i = ~clk_i;

    obstacle_scheduler dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .frame_i    (frame_i),
        .run_i      (run_i),
        .clear_i    (clear_i),
        .rand_i     (rand_i),
        .level_up_i (level_up_i),
        .busy_i     (busy_i),
        .spawn_o    (spawn_o),
        .level_o    (level_o),
        .gap_o      (gap_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: game started, frames left before arming, armed flag, pending grant slot.
    int  m_level, m_rr, m_wait, m_pending;
    bit  m_started, m_armed;
    logic [2:0] last_spawn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_gap(input int lvl);
        int g;
        g = 60 - 6 * lvl;
        return (g < 24) ? 24 : g;
    endfunction

    function automatic int model_thr(input int lvl);
        int t;
        t = 4 + 2 * lvl;
        return (t > 16) ? 16 : t;
    endfunction

    task automatic model_reset();
        m_level   = 0;
        m_rr      = 0;
        m_wait    = 0;
        m_pending = -1;
        m_started = 0;
        m_armed   = 0;
    endtask

    task automatic model_step(input bit run, input bit clr, input bit frm, input bit lvl,
                              input logic [15:0] rnd, input logic [2:0] bsy);
        int gap, nl;
        if (clr) begin
            model_reset();
            return;
        end
        if (!run) return;
        gap = model_gap(m_level);
        nl  = (lvl && m_level < 7) ? m_level + 1 : m_level;
        if (m_pending >= 0) begin
            m_rr      = (m_pending + 1) % N;
            m_wait    = gap + int'(rnd[7:4]);
            m_pending = -1;
        end else if (!m_started) begin
            m_started = 1;
            m_wait    = gap;
        end else if (!m_armed) begin
            if (frm) begin
                if (m_wait <= 1) m_armed = 1;
                else             m_wait--;
            end
        end else if (frm && int'(rnd[3:0]) < model_thr(m_level)) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_rr + k) % N;
                if (m_pending < 0 && !bsy[s] && (s == 2 || m_level >= 1)) begin
                    m_pending = s;
                    m_armed   = 0;
                end
            end
        end
        m_level = nl;
    endtask

    task automatic cycle(input bit run, input bit clr, input bit frm, input bit lvl,
                         input logic [15:0] rnd, input logic [2:0] bsy);
        logic [2:0] exp_spawn;
        @(negedge clk_i);
        run_i      = run;
        clear_i    = clr;
        frame_i    = frm;
        level_up_i = lvl;
        rand_i     = rnd;
        busy_i     = bsy;
        #1;
        exp_spawn = (m_pending >= 0 && run) ? 3'(1 << m_pending) : 3'b000;
        check("spawn", 32'(spawn_o), 32'(exp_spawn));
        check("level", 32'(level_o), 32'(m_level));
        check("gap", 32'(gap_o), 32'(model_gap(m_level)));
        last_spawn = spawn_o;
        @(posedge clk_i);
        model_step(run, clr, frm, lvl, rnd, bsy);
    endtask

    task automatic wait_spawn(input int max_cycles, input logic [15:0] rnd, input logic [2:0] bsy,
                              output logic [2:0] s, output int frames);
        bit f;
        s      = '0;
        frames = 0;
        for (int i = 0; i < max_cycles; i++) begin
            f = (i % 2) == 1;
            cycle(1, 0, f, 0, rnd, bsy);
            if (last_spawn != 3'b000) begin
                s = last_spawn;
                return;
            end
            if (f) frames++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] s;
        logic [2:0] acc;
        int frames;

        rst_ni = 1'b0; run_i = 0; clear_i = 0; frame_i = 0; level_up_i = 0;
        rand_i = '0; busy_i = '0;
        model_reset();
        #5;
        check("rst_spawn", 32'(spawn_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_gap", 32'(gap_o), 60);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Level 0: first cooldown of 60 frames, then the cactus is the only candidate.
        cycle(1, 0, 0, 0, 16'h0000, 3'b000);
        acc = '0;
        for (int i = 0; i < 60; i++) begin
            cycle(1, 0, 1, 0, 16'h0000, 3'b000);
            acc |= last_spawn;
            cycle(1, 0, 0, 0, 16'h0000, 3'b000);
            acc |= last_spawn;
        end
        check("tp1_quiet", 32'(acc), 0);
        cycle(1, 0, 1, 0, 16'h0000, 3'b000);
        check("tp1_latency", 32'(last_spawn), 0);
        cycle(1, 0, 0, 0, 16'h0000, 3'b000);
        check("tp1_grant", 32'(last_spawn), 32'(3'b100));
        cycle(1, 0, 0, 0, 16'h0000, 3'b000);
        check("tp1_single", 32'(last_spawn), 0);

        // Level 1: birds join the round-robin.
        cycle(1, 0, 0, 1, 16'h0000, 3'b000);
        wait_spawn(300, 16'h0000, 3'b000, s, frames);
        check("tp2_g0", 32'(s), 32'(3'b001));
        check("tp2_frames0", 32'(frames), 61);
        wait_spawn(300, 16'h0000, 3'b000, s, frames);
        check("tp2_g1", 32'(s), 32'(3'b010));
        check("tp2_frames1", 32'(frames), 55);
        wait_spawn(300, 16'h0000, 3'b000, s, frames);
        check("tp2_g2", 32'(s), 32'(3'b100));
        check("tp2_frames2", 32'(frames), 55);

        // Level saturation and gap floor.
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 1, 16'h0000, 3'b000);
        check("tp3_level", 32'(level_o), 7);
        check("tp3_gap", 32'(gap_o), 24);
        cycle(1, 0, 0, 1, 16'h0000, 3'b000);
        check("tp3_level_sat", 32'(level_o), 7);

        // All slots busy: no grant even once armed; freeing slot 1 grants it.
        wait_spawn(220, 16'h000F, 3'b111, s, frames);
        check("tp4_blocked", 32'(s), 0);
        wait_spawn(20, 16'h000F, 3'b111, s, frames);
        check("tp4_blocked10", 32'(s), 0);
        cycle(1, 0, 1, 0, 16'h00AF, 3'b101);
        cycle(1, 0, 0, 0, 16'h0060, 3'b101);
        check("tp4_grant", 32'(last_spawn), 32'(3'b010));

        // Cooldown of 30 frozen for 5 frames, then resumes: 30 frames to arm + 1 to grant.
        for (int i = 0; i < 10; i++) cycle(0, 0, (i % 2) == 1, (i == 3), 16'($urandom), 3'b000);
        wait_spawn(200, 16'h0000, 3'b000, s, frames);
        check("tp5_grant", 32'(s), 32'(3'b100));
        check("tp5_frames", 32'(frames), 31);

        // Clear during GRANT.
        for (int i = 0; i < 24; i++) begin
            cycle(1, 0, 1, 0, 16'h0000, 3'b000);
            cycle(1, 0, 0, 0, 16'h0000, 3'b000);
        end
        cycle(1, 0, 1, 0, 16'h0000, 3'b000);
        cycle(1, 1, 0, 0, 16'h0000, 3'b000);
        cycle(0, 0, 0, 0, 16'h0000, 3'b000);
        check("tp6_spawn", 32'(last_spawn), 0);
        check("tp6_level", 32'(level_o), 0);
        check("tp6_gap", 32'(gap_o), 60);

        // Async reset while a spawn pulse is live.
        cycle(1, 0, 0, 0, 16'h0000, 3'b000);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 16'h0000, 3'b000);
        for (int i = 0; i < 60; i++) begin
            cycle(1, 0, 1, 0, 16'h0000, 3'b000);
            cycle(1, 0, 0, 0, 16'h0000, 3'b000);
        end
        cycle(1, 0, 1, 0, 16'h0000, 3'b000);
        @(negedge clk_i);
        run_i = 1; frame_i = 0; level_up_i = 0; clear_i = 0;
        #1;
        check("tp7_pre_spawn", 32'(spawn_o), 32'(3'b001));
        rst_ni = 1'b0;
        #1;
        check("tp7_rst_spawn", 32'(spawn_o), 0);
        check("tp7_rst_level", 32'(level_o), 0);
        check("tp7_rst_gap", 32'(gap_o), 60);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 399) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0,
                  16'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
